// File: rtl/muller_pipeline.sv
// Clocked Muller C-element pipeline with bundled-data registers and
// 4-phase req/ack handshakes on the producer and consumer sides.
module muller_pipeline #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_req,
    output logic             in_ack,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_data,
    output logic             idle
);

    logic req_s;
    logic ack_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = in_req;
            assign ack_s = out_ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] req_sync_q;
            logic [SYNC_STAGES-1:0] ack_sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_sync_q <= '0;
                    ack_sync_q <= '0;
                end else begin
                    req_sync_q[0] <= in_req;
                    ack_sync_q[0] <= out_ack;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        req_sync_q[i] <= req_sync_q[i-1];
                        ack_sync_q[i] <= ack_sync_q[i-1];
                    end
                end
            end

            assign req_s = req_sync_q[SYNC_STAGES-1];
            assign ack_s = ack_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [DEPTH-1:0]            c_q;
    logic [DEPTH-1:0]            c_d;
    logic [DEPTH-1:0]            prev_c;
    logic [DEPTH-1:0]            next_c;
    logic [DEPTH-1:0]            rise;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_d;

    assign prev_c = {c_q[DEPTH-2:0], req_s};
    assign next_c = {ack_s, c_q[DEPTH-1:1]};

    // a = prev, b = ~next: set on a&b, clear on ~a&~b, otherwise hold
    assign c_d  = (prev_c & ~next_c) | (c_q & (prev_c | ~next_c));
    assign rise = c_d & ~c_q;

    always_comb begin
        d_d    = d_q;
        d_d[0] = rise[0] ? in_data : d_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            d_d[i] = rise[i] ? d_q[i-1] : d_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            d_q <= '0;
        end else begin
            c_q <= c_d;
            d_q <= d_d;
        end
    end

    assign in_ack   = c_q[0];
    assign out_req  = c_q[DEPTH-1];
    assign out_data = d_q[DEPTH-1];
    assign idle     = ~|c_q & ~ack_s;

endmodule

// File: tb/tb_muller_pipeline.sv
// Bench for muller_pipeline: default config plus a DEPTH=2,
// SYNC_STAGES=0, WIDTH=1 instance, scoreboard-checked.
module tb_muller_pipeline;

    localparam int TMO = 500;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_req_a, in_ack_a, out_req_a, out_ack_a, idle_a;
    logic [7:0] in_data_a, out_data_a;

    logic       in_req_b, in_ack_b, out_req_b, out_ack_b, idle_b;
    logic [0:0] in_data_b, out_data_b;

    logic [7:0] sb[$];
    int         errs   = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    muller_pipeline #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_req   (in_req_a),
        .in_ack   (in_ack_a),
        .in_data  (in_data_a),
        .out_req  (out_req_a),
        .out_ack  (out_ack_a),
        .out_data (out_data_a),
        .idle     (idle_a)
    );

    muller_pipeline #(.WIDTH(1), .DEPTH(2), .SYNC_STAGES(0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_req   (in_req_b),
        .in_ack   (in_ack_b),
        .in_data  (in_data_b),
        .out_req  (out_req_b),
        .out_ack  (out_ack_b),
        .out_data (out_data_b),
        .idle     (idle_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_a(input logic [7:0] v, input int dly);
        int n;
        repeat (dly) @(negedge clk);
        in_data_a = v;
        in_req_a  = 1'b1;
        sb.push_back(v);
        n = 0;
        while (in_ack_a !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("put_ack", in_ack_a, 1);
        in_req_a = 1'b0;
        n = 0;
        while (in_ack_a !== 1'b0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("put_rtz", in_ack_a, 0);
    endtask

    task automatic get_a(input int dly);
        int          n;
        logic [31:0] exp;
        n = 0;
        while (out_req_a !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("get_req", out_req_a, 1);
        if (sb.size() > 0) exp = 32'(sb.pop_front());
        else exp = 32'hDEAD;
        check("get_data", out_data_a, exp);
        repeat (dly) @(negedge clk);
        out_ack_a = 1'b1;
        n = 0;
        while (out_req_a !== 1'b0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("get_rtz", out_req_a, 0);
        out_ack_a = 1'b0;
    endtask

    task automatic wait_b(input logic want_ack, input logic lvl);
        int n;
        n = 0;
        while ((want_ack ? in_ack_b : out_req_b) !== lvl && n < TMO) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int ta, tr, cnt, cnt2;
        rst_n     = 1'b0;
        in_req_a  = 1'b0;
        out_ack_a = 1'b0;
        in_data_a = '0;
        in_req_b  = 1'b0;
        out_ack_b = 1'b0;
        in_data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ack", in_ack_a, 0);
        check("rst_out_req", out_req_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_idle", idle_a, 1);
        check("rst_idle_b", idle_b, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single token latency
        in_data_a = 8'hA5;
        in_req_a  = 1'b1;
        sb.push_back(8'hA5);
        ta = 0;
        tr = 0;
        for (int n = 1; n <= 20 && tr == 0; n++) begin
            @(negedge clk);
            if (ta == 0 && in_ack_a) begin
                ta = n;
                in_req_a = 1'b0;
            end
            if (tr == 0 && out_req_a) tr = n;
        end
        check("lat_ack", ta, 3);
        check("lat_req", tr, 6);
        get_a(0);
        repeat (6) @(negedge clk);
        check("single_idle", idle_a, 1);

        // capacity with consumer stalled
        put_a(8'h11, 0);
        put_a(8'h22, 0);
        repeat (5) @(negedge clk);
        check("cap_state", dut_a.c_q, 4'b1010);
        check("cap_busy", idle_a, 0);
        in_data_a = 8'h33;
        in_req_a  = 1'b1;
        sb.push_back(8'h33);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (in_ack_a) cnt++;
        end
        check("cap_block", cnt, 0);

        // drain
        fork
            begin
                int n;
                n = 0;
                while (in_ack_a !== 1'b1 && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                check("cap_late_ack", in_ack_a, 1);
                in_req_a = 1'b0;
                n = 0;
                while (in_ack_a !== 1'b0 && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                check("cap_late_rtz", in_ack_a, 0);
            end
            begin
                repeat (3) get_a(0);
            end
        join
        check("drain_empty", sb.size(), 0);

        // random streaming
        fork
            for (int i = 0; i < 64; i++)
                put_a(8'($urandom), $urandom_range(0, 7));
            for (int i = 0; i < 64; i++)
                get_a($urandom_range(0, 7));
        join
        check("stream_empty", sb.size(), 0);
        repeat (6) @(negedge clk);
        check("stream_idle", idle_a, 1);

        // DEPTH=2, SYNC_STAGES=0: latency
        in_data_b = 1'b1;
        in_req_b  = 1'b1;
        ta = 0;
        tr = 0;
        for (int n = 1; n <= 20 && tr == 0; n++) begin
            @(negedge clk);
            if (ta == 0 && in_ack_b) begin
                ta = n;
                in_req_b = 1'b0;
            end
            if (tr == 0 && out_req_b) tr = n;
        end
        check("b_lat_ack", ta, 1);
        check("b_lat_req", tr, 2);
        check("b_data1", out_data_b, 1);

        // capacity of one token
        repeat (3) @(negedge clk);
        in_data_b = 1'b0;
        in_req_b  = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ack_b) cnt++;
        end
        check("b_cap_block", cnt, 0);
        check("b_hold_data", out_data_b, 1);
        out_ack_b = 1'b1;
        wait_b(1'b0, 1'b0);
        check("b_rtz1", out_req_b, 0);
        out_ack_b = 1'b0;
        wait_b(1'b1, 1'b1);
        check("b_cap_ack", in_ack_b, 1);
        in_req_b = 1'b0;
        wait_b(1'b0, 1'b1);
        check("b_req2", out_req_b, 1);
        check("b_data2", out_data_b, 0);
        out_ack_b = 1'b1;
        wait_b(1'b0, 1'b0);
        check("b_rtz2", out_req_b, 0);
        out_ack_b = 1'b0;
        repeat (3) @(negedge clk);
        check("b_idle", idle_b, 1);

        // protocol violations: early out_ack, 1-cycle in_req pulse
        out_ack_b = 1'b1;
        @(negedge clk);
        check("b_ack_busy", idle_b, 0);
        in_data_b = 1'b1;
        in_req_b  = 1'b1;
        @(negedge clk);
        check("b_pulse_ack", in_ack_b, 1);
        in_req_b = 1'b0;
        cnt  = 0;
        cnt2 = 0;
        repeat (10) begin
            @(negedge clk);
            if (in_ack_b) cnt++;
            if (out_req_b) cnt2++;
        end
        check("b_pulse_hold", cnt, 10);
        check("b_early_ack_hold", cnt2, 0);
        out_ack_b = 1'b0;
        wait_b(1'b0, 1'b1);
        check("b_pulse_req", out_req_b, 1);
        check("b_pulse_data", out_data_b, 1);
        wait_b(1'b1, 1'b0);
        check("b_pulse_rtz", in_ack_b, 0);
        out_ack_b = 1'b1;
        wait_b(1'b0, 1'b0);
        out_ack_b = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset mid-transfer
        put_a(8'h5A, 0);
        in_data_a = 8'hC3;
        in_req_a  = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_rst_req", out_req_a, 1);
        check("pre_rst_data", out_data_a, 8'h5A);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ack", in_ack_a, 0);
        check("mid_rst_out_req", out_req_a, 0);
        check("mid_rst_out_data", out_data_a, 0);
        check("mid_rst_idle", idle_a, 1);
        sb.delete();
        in_req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/muller_pipeline.md
Name: muller_pipeline

Overview:
- Parametrised, clock-emulated Muller C-element pipeline: DEPTH C-element stages, each with a WIDTH-bit bundled-data register.
- 4-phase (return-to-zero) req/ack handshake on both ends; incoming req and ack are synchronised by SYNC_STAGES flops.
- Successor to the single two-input C-element: C-element state is a clocked register rather than a latch, so the block is usable as an async-style FIFO between tile I/O and internal logic.

Parameters:
WIDTH, 8, data bits per token (>=1)
DEPTH, 4, number of C-element stages (>=2); token capacity = DEPTH/2 (floor)
SYNC_STAGES, 2, synchroniser flops on in_req and out_ack (0 = sampled directly, no synchroniser)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_req  input  1  producer request, 4-phase, may be asynchronous to clk
in_ack  output  1  acknowledge to producer
in_data  input  WIDTH  bundled data; held stable from in_req rise until in_ack rise
out_req  output  1  request to consumer
out_ack  input  1  consumer acknowledge, 4-phase, may be asynchronous to clk
out_data  output  WIDTH  bundled data, valid while out_req=1
idle  output  1  1 when every stage C-state is 0 and synchronised out_ack is 0

Behaviour:
- Reset (rst_n=0, asynchronous): all c[i]=0, all d[i]=0, all synchroniser flops=0. Hence in_ack=0, out_req=0, out_data=0, idle=1. Applies mid-transfer; in-flight tokens are discarded.
- Synchronisers: req_s and ack_s are in_req and out_ack delayed through SYNC_STAGES flops, with no metastability filtering beyond this.
- C-element stage i, updated on every posedge clk from previous-cycle register values:
  - a = (i==0 ? req_s : c[i-1])
  - b = ~(i==DEPTH-1 ? ack_s : c[i+1])
  - a=b=1 -> c[i]<=1; a=b=0 -> c[i]<=0; otherwise c[i] holds.
- Data capture: on the edge where c[i] goes 0->1, d[i] <= (i==0 ? in_data : d[i-1]). d[i] holds at all other times, including on the 1->0 transition.
- Outputs, all registered:
  - in_ack = c[0]
  - out_req = c[DEPTH-1]
  - out_data = d[DEPTH-1]
  - idle = ~|c & ~ack_s
- Latency, empty pipeline: in_req high before edge k -> in_ack high after edge k+SYNC_STAGES -> out_req high after edge k+SYNC_STAGES+DEPTH-1, with out_data valid in the same cycle.
- Full: out_ack held 0 means at most DEPTH/2 tokens are accepted. A further in_req is not acknowledged and in_ack stays 0 until downstream space frees.
- Protocol violations:
  - No error flag; behaviour is exactly the C-element rule.
  - in_req dropped before in_ack: c[0] holds.
  - out_ack raised while out_req=0: c[DEPTH-1] holds at 0 and does not rise until out_ack returns to 0.
- Simultaneous events: input and output handshakes proceed independently in the same cycle; no priority logic.
- No token is duplicated or lost under legal 4-phase operation.

Test Plan:
- Reset: drive rst_n=0 mid-transfer, asynchronously between clock edges -> in_ack, out_req, out_data go 0 and idle goes 1 without waiting for a clock edge.
- Single token (WIDTH=8, DEPTH=4, SYNC_STAGES=2), in_data=0xA5, in_req rises before edge k:
  - in_ack=1 after edge k+2
  - out_req=1 after edge k+5 with out_data=0xA5
  - full return-to-zero on both sides leaves idle=1
- Capacity, out_ack held 0:
  - tokens 0x11 and 0x22 are acknowledged
  - third in_req (0x33) sees in_ack stay 0 for 50 cycles
  - state reaches c=[0,1,0,1] after the second in_req falls
- Drain order: release consumer from the capacity case -> out_data sequence 0x11, 0x22, 0x33, each valid with out_req=1; no token lost or duplicated.
- Streaming: 64 random tokens with random handshake delays (0-7 cycles) on both sides -> output sequence equals input sequence.
- Parameter sweep, DEPTH=2, SYNC_STAGES=0, WIDTH=1:
  - single token latency: out_req high after edge k+1
  - capacity exactly 1 token
- Protocol violation: in_req pulsed high for 1 cycle with SYNC_STAGES=0 -> c[0] rises and holds, in_ack=1 with no return until the producer completes the handshake.
